// File: rtl/apb_master_nslv.sv
// APB v3 bridge master: single read/write command in, decoded slave access out,
// one-cycle response pulse carrying read data and error (PSLVERR, decode, timeout).
module apb_master_nslv #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 8,
  parameter int NUM_SLV     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  // state     | meaning
  // ST_IDLE   | no transfer; cmd_ready high, decode errors answered here
  // ST_SETUP  | PSEL high, PENABLE low for one cycle
  // ST_ACCESS | PSEL and PENABLE high until PREADY or timeout

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [SEL_W:0]   NUM_SLV_L = (SEL_W + 1)'(NUM_SLV);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;

  logic [SEL_W-1:0]   w_idx;
  logic               w_idx_ok;
  logic [NUM_SLV-1:0] w_sel;
  logic               w_pready;
  logic               w_pslverr;
  logic [DATA_W-1:0]  w_prdata;

  assign cmd_ready = RST_N && (r_state == ST_IDLE);

  assign w_idx    = (NUM_SLV > 1) ? cmd_addr[ADDR_W-1 -: SEL_W] : '0;
  assign w_idx_ok = ({1'b0, w_idx} < NUM_SLV_L);
  assign w_sel    = NUM_SLV'(1) << w_idx;

  // Only the selected slave's response is visible to the FSM.
  always_comb begin
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    w_prdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_idx == SEL_W'(i)) begin
        w_pready  = PREADY[i];
        w_pslverr = PSLVERR[i];
        w_prdata  = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (w_idx_ok) begin
              PADDR   <= cmd_addr;
              PWRITE  <= cmd_write;
              PWDATA  <= cmd_wdata;
              PSEL    <= w_sel;
              r_idx   <= w_idx;
              r_state <= ST_SETUP;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          r_cnt   <= CNT_LOAD;
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_pready) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= w_pslverr;
            rsp_rdata <= (!PWRITE && !w_pslverr) ? w_prdata : '0;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end else if (TIMEOUT_CYC > 0) begin
            // Down-counter loaded with TIMEOUT_CYC-1; terminal count ends the last allowed ACCESS cycle.
            if (r_cnt == '0) begin
              PSEL      <= '0;
              PENABLE   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Directed bench for apb_master_nslv: a 2-slave instance with a 4-cycle timeout
// and a 3-slave instance without timeout, sharing clock, reset and command fields.
module tb_apb_master_nslv;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        cmd_write;
  logic [8:0]  cmd_addr;
  logic [7:0]  cmd_wdata;

  logic        cmd_valid_a, cmd_ready_a, rsp_valid_a, rsp_err_a, penable_a, pwrite_a;
  logic [7:0]  rsp_rdata_a, pwdata_a;
  logic [8:0]  paddr_a;
  logic [1:0]  psel_a, pready_a, pslverr_a;
  logic [15:0] prdata_a;

  logic        cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_err_b, penable_b, pwrite_b;
  logic [7:0]  rsp_rdata_b, pwdata_b;
  logic [8:0]  paddr_b;
  logic [2:0]  psel_b, pready_b, pslverr_b;
  logic [23:0] prdata_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  apb_master_nslv #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(2), .TIMEOUT_CYC(4)) u_dut_a (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .PSEL(psel_a), .PENABLE(penable_a), .PWRITE(pwrite_a), .PADDR(paddr_a),
    .PWDATA(pwdata_a), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
  );

  apb_master_nslv #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(3), .TIMEOUT_CYC(0)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .PSEL(psel_b), .PENABLE(penable_b), .PWRITE(pwrite_b), .PADDR(paddr_b),
    .PWDATA(pwdata_b), .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_valid_a = 1'b0; pready_a = '0; pslverr_a = '0; prdata_a = '0;
    cmd_valid_b = 1'b0; pready_b = '0; pslverr_b = '0; prdata_b = '0;
    step(); step();

    chk("rst_psel",      32'(psel_a),      32'h0);
    chk("rst_penable",   32'(penable_a),   32'h0);
    chk("rst_paddr",     32'(paddr_a),     32'h0);
    chk("rst_pwdata",    32'(pwdata_a),    32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid_a), 32'h0);
    chk("rst_rsp_err",   32'(rsp_err_a),   32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready_a), 32'h0);
    chk("rst_psel_b",    32'(psel_b),      32'h0);

    // A command presented during reset must be ignored.
    cmd_valid_a = 1'b1; cmd_addr = 9'h0A5;
    step();
    chk("rst_cmd_ignored", 32'(psel_a), 32'h0);
    cmd_valid_a = 1'b0;
    RST_N = 1'b1;
    #1;
    chk("rel_cmd_ready", 32'(cmd_ready_a), 32'h1);
    step();

    // Zero-wait write to slave 0.
    cmd_write = 1'b1; cmd_addr = 9'h0A5; cmd_wdata = 8'h3C; pready_a = 2'b01;
    cmd_valid_a = 1'b1;
    step();
    cmd_valid_a = 1'b0; cmd_addr = 9'h155; cmd_wdata = 8'hFF;
    chk("wr_setup_psel",    32'(psel_a),      32'h1);
    chk("wr_setup_penable", 32'(penable_a),   32'h0);
    chk("wr_setup_paddr",   32'(paddr_a),     32'h0A5);
    chk("wr_setup_pwrite",  32'(pwrite_a),    32'h1);
    chk("wr_setup_pwdata",  32'(pwdata_a),    32'h3C);
    chk("wr_setup_ready",   32'(cmd_ready_a), 32'h0);
    step();
    chk("wr_access_penable", 32'(penable_a),   32'h1);
    chk("wr_access_psel",    32'(psel_a),      32'h1);
    chk("wr_access_rsp",     32'(rsp_valid_a), 32'h0);
    step();
    chk("wr_rsp_valid",   32'(rsp_valid_a), 32'h1);
    chk("wr_rsp_err",     32'(rsp_err_a),   32'h0);
    chk("wr_rsp_rdata",   32'(rsp_rdata_a), 32'h0);
    chk("wr_end_psel",    32'(psel_a),      32'h0);
    chk("wr_end_penable", 32'(penable_a),   32'h0);
    chk("wr_end_ready",   32'(cmd_ready_a), 32'h1);
    chk("wr_idle_paddr",  32'(paddr_a),     32'h0A5);
    step();
    chk("wr_rsp_pulse", 32'(rsp_valid_a), 32'h0);

    // Read from slave 1 with three wait states; slave 0 is ready/erroring as a decoy.
    cmd_write = 1'b0; cmd_addr = 9'h1F0; pready_a = 2'b01; pslverr_a = 2'b01;
    prdata_a = 16'h5AEE;
    cmd_valid_a = 1'b1;
    step();
    cmd_valid_a = 1'b0; cmd_addr = 9'h000;
    chk("rd_setup_psel",   32'(psel_a),   32'h2);
    chk("rd_setup_pwrite", 32'(pwrite_a), 32'h0);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("rd_wait_penable", 32'(penable_a),   32'h1);
      chk("rd_wait_paddr",   32'(paddr_a),     32'h1F0);
      chk("rd_wait_rsp",     32'(rsp_valid_a), 32'h0);
      step();
    end
    pready_a = 2'b10;
    chk("rd_last_access", 32'(penable_a), 32'h1);
    step();
    chk("rd_rsp_valid", 32'(rsp_valid_a), 32'h1);
    chk("rd_rsp_rdata", 32'(rsp_rdata_a), 32'h5A);
    chk("rd_rsp_err",   32'(rsp_err_a),   32'h0);
    chk("rd_end_psel",  32'(psel_a),      32'h0);
    pready_a = 2'b00; pslverr_a = 2'b00;
    step();

    // Slave error on a read: error flagged, data forced to zero.
    cmd_addr = 9'h1F0; pready_a = 2'b10; pslverr_a = 2'b10; prdata_a = 16'h5A00;
    cmd_valid_a = 1'b1;
    step();
    cmd_valid_a = 1'b0;
    step(); step();
    chk("slverr_rsp_valid", 32'(rsp_valid_a), 32'h1);
    chk("slverr_rsp_err",   32'(rsp_err_a),   32'h1);
    chk("slverr_rsp_rdata", 32'(rsp_rdata_a), 32'h0);
    pready_a = 2'b01; pslverr_a = 2'b00;
    step();

    // Timeout: slave 1 never ready, abort after four ACCESS cycles.
    cmd_addr = 9'h100;
    cmd_valid_a = 1'b1;
    step();
    cmd_valid_a = 1'b0;
    chk("to_setup_psel", 32'(psel_a), 32'h2);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("to_access_penable", 32'(penable_a),   32'h1);
      chk("to_access_rsp",     32'(rsp_valid_a), 32'h0);
      step();
    end
    chk("to_rsp_valid",   32'(rsp_valid_a), 32'h1);
    chk("to_rsp_err",     32'(rsp_err_a),   32'h1);
    chk("to_rsp_rdata",   32'(rsp_rdata_a), 32'h0);
    chk("to_end_psel",    32'(psel_a),      32'h0);
    chk("to_end_penable", 32'(penable_a),   32'h0);
    pready_a = 2'b00;
    step();

    // Three-slave instance: index 3 is a decode error.
    cmd_addr = 9'h1C0;
    cmd_valid_b = 1'b1;
    step();
    cmd_valid_b = 1'b0;
    chk("dec_rsp_valid", 32'(rsp_valid_b), 32'h1);
    chk("dec_rsp_err",   32'(rsp_err_b),   32'h1);
    chk("dec_psel",      32'(psel_b),      32'h0);
    chk("dec_penable",   32'(penable_b),   32'h0);
    chk("dec_ready",     32'(cmd_ready_b), 32'h1);
    step();
    chk("dec_rsp_pulse", 32'(rsp_valid_b), 32'h0);

    // Slave 2 read, six wait states, no timeout configured.
    cmd_addr = 9'h100; prdata_b = 24'hC31122; pready_b = 3'b011;
    cmd_valid_b = 1'b1;
    step();
    cmd_valid_b = 1'b0;
    chk("s2_setup_psel", 32'(psel_b), 32'h4);
    step();
    for (int k = 0; k < 6; k++) begin
      chk("s2_wait_penable", 32'(penable_b),   32'h1);
      chk("s2_wait_rsp",     32'(rsp_valid_b), 32'h0);
      step();
    end
    pready_b = 3'b100;
    step();
    chk("s2_rsp_valid", 32'(rsp_valid_b), 32'h1);
    chk("s2_rsp_rdata", 32'(rsp_rdata_b), 32'hC3);
    chk("s2_rsp_err",   32'(rsp_err_b),   32'h0);
    pready_b = 3'b000;
    step();

    // Reset in the middle of an ACCESS phase.
    cmd_addr = 9'h0A5; pready_a = 2'b00;
    cmd_valid_a = 1'b1;
    step();
    cmd_valid_a = 1'b0;
    step();
    chk("mid_access_penable", 32'(penable_a), 32'h1);
    RST_N = 1'b0;
    step();
    chk("mid_rst_psel",    32'(psel_a),      32'h0);
    chk("mid_rst_penable", 32'(penable_a),   32'h0);
    chk("mid_rst_rsp",     32'(rsp_valid_a), 32'h0);
    chk("mid_rst_paddr",   32'(paddr_a),     32'h0);
    chk("mid_rst_ready",   32'(cmd_ready_a), 32'h0);
    RST_N = 1'b1;
    step();
    chk("post_rst_ready", 32'(cmd_ready_a), 32'h1);
    chk("post_rst_rsp",   32'(rsp_valid_a), 32'h0);

    // Back-to-back: second command accepted in the response cycle of the first.
    pready_a = 2'b11; cmd_write = 1'b1; cmd_addr = 9'h010; cmd_wdata = 8'h11;
    cmd_valid_a = 1'b1;
    step();
    cmd_valid_a = 1'b0;
    chk("b2b_first_psel", 32'(psel_a), 32'h1);
    step(); step();
    chk("b2b_first_rsp",   32'(rsp_valid_a), 32'h1);
    chk("b2b_first_ready", 32'(cmd_ready_a), 32'h1);
    cmd_write = 1'b0; cmd_addr = 9'h1F0; prdata_a = 16'h5A00;
    cmd_valid_a = 1'b1;
    step();
    cmd_valid_a = 1'b0;
    chk("b2b_second_psel",    32'(psel_a),      32'h2);
    chk("b2b_second_penable", 32'(penable_a),   32'h0);
    chk("b2b_second_norsp",   32'(rsp_valid_a), 32'h0);
    step(); step();
    chk("b2b_second_rsp",   32'(rsp_valid_a), 32'h1);
    chk("b2b_second_rdata", 32'(rsp_rdata_a), 32'h5A);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
